// File: rtl/aes_pkg.sv
// AES constants shared by the SubBytes datapath and key expansion.
// Holds the forward and inverse S-box tables (indexed by the input byte)
// and the byte width used to slice words into lanes.
package aes_pkg;

  localparam int BYTE_W = 8;

  localparam logic [7:0] SBOX_FWD [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] SBOX_INV [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/sbox_lane.sv
// Single-byte S-box lookup, purely combinational.
// Ports:
//   din  - input byte
//   inv  - 1 selects the inverse S-box (ignored when INV_EN=0)
//   dout - substituted byte
// With INV_EN=0 only the forward table is built.
module sbox_lane
  import aes_pkg::*;
#(
  parameter bit INV_EN = 1'b1
) (
  input  logic [BYTE_W-1:0] din,
  input  logic              inv,
  output logic [BYTE_W-1:0] dout
);

  generate
    if (INV_EN) begin : g_fwd_inv
      assign dout = inv ? SBOX_INV[din] : SBOX_FWD[din];
    end else begin : g_fwd
      logic inv_unused;
      assign inv_unused = inv;
      assign dout       = SBOX_FWD[din];
    end
  endgenerate

endmodule

// File: rtl/sub_bytes_pipe.sv
// Pipelined SubBytes engine: applies the AES S-box (or inverse S-box) to
// each of LANES bytes of a word, one word per cycle, with valid/ready
// handshakes on both sides.
// Parameters:
//   LANES       - bytes per word (16 = full state, 4 = SubWord)
//   PIPE_STAGES - 1 or 2 register stages
//   INV_EN      - 1 honours in_inv, 0 builds forward tables only
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   in_valid/in_ready    - input handshake; in_data/in_inv taken on transfer
//   out_valid/out_ready  - output handshake; out_data/out_inv held while stalled
//   busy                 - any stage holds a word
module sub_bytes_pipe
  import aes_pkg::*;
#(
  parameter int LANES       = 16,
  parameter int PIPE_STAGES = 1,
  parameter bit INV_EN      = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BYTE_W*LANES-1:0] in_data,
  input  logic                    in_inv,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BYTE_W*LANES-1:0] out_data,
  output logic                    out_inv,
  output logic                    busy
);

  localparam int W = BYTE_W * LANES;

  logic [W-1:0] lut_in;
  logic [W-1:0] lut_out;
  logic         lut_inv;
  logic         inv_req;

  // Without the inverse table the flag is meaningless, so it is forced low
  // and travels as 0.
  assign inv_req = in_inv & INV_EN;

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      sbox_lane #(.INV_EN(INV_EN)) u_lane (
        .din  (lut_in[BYTE_W*i +: BYTE_W]),
        .inv  (lut_inv),
        .dout (lut_out[BYTE_W*i +: BYTE_W])
      );
    end
  endgenerate

  generate
    if (PIPE_STAGES == 1) begin : g_one
      logic         vld_p1;
      logic [W-1:0] data_p1;
      logic         inv_p1;
      logic         load_p1;

      assign lut_in  = in_data;
      assign lut_inv = inv_req;
      assign load_p1 = !vld_p1 || out_ready;

      // Stage 1: lookup result registered straight from the input
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          vld_p1  <= 1'b0;
          data_p1 <= '0;
          inv_p1  <= 1'b0;
        end else if (load_p1) begin
          vld_p1 <= in_valid;
          if (in_valid) begin
            data_p1 <= lut_out;
            inv_p1  <= lut_inv;
          end
        end
      end

      assign in_ready  = load_p1;
      assign out_valid = vld_p1;
      assign out_data  = data_p1;
      assign out_inv   = inv_p1;
      assign busy      = vld_p1;
    end else if (PIPE_STAGES == 2) begin : g_two
      logic         vld_p1;
      logic [W-1:0] data_p1;
      logic         inv_p1;
      logic         vld_p2;
      logic [W-1:0] data_p2;
      logic         inv_p2;
      logic         load_p1;
      logic         load_p2;

      assign load_p2 = !vld_p2 || out_ready;
      // Stage 1 empties whenever stage 2 can take its word.
      assign load_p1 = !vld_p1 || load_p2;

      // Stage 1: raw bytes and inv flag
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          vld_p1  <= 1'b0;
          data_p1 <= '0;
          inv_p1  <= 1'b0;
        end else if (load_p1) begin
          vld_p1 <= in_valid;
          if (in_valid) begin
            data_p1 <= in_data;
            inv_p1  <= inv_req;
          end
        end
      end

      assign lut_in  = data_p1;
      assign lut_inv = inv_p1;

      // Stage 2: substituted bytes
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          vld_p2  <= 1'b0;
          data_p2 <= '0;
          inv_p2  <= 1'b0;
        end else if (load_p2) begin
          vld_p2 <= vld_p1;
          if (vld_p1) begin
            data_p2 <= lut_out;
            inv_p2  <= lut_inv;
          end
        end
      end

      assign in_ready  = load_p1;
      assign out_valid = vld_p2;
      assign out_data  = data_p2;
      assign out_inv   = inv_p2;
      assign busy      = vld_p1 || vld_p2;
    end else begin : g_bad
      $error("sub_bytes_pipe: PIPE_STAGES must be 1 or 2");
    end
  endgenerate

endmodule

// File: tb/tb_sub_bytes_pipe.sv
module tb_sub_bytes_pipe;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic [127:0] in_data = '0;
  logic         in_inv = 1'b0;
  logic         out_ready = 1'b0;

  logic         u1_ir, u1_ov, u1_oi, u1_busy;
  logic [127:0] u1_od;
  logic         u2_ir, u2_ov, u2_oi, u2_busy;
  logic [127:0] u2_od;
  logic         u0_ir, u0_ov, u0_oi, u0_busy;
  logic [127:0] u0_od;
  logic         u4_ir, u4_ov, u4_oi, u4_busy;
  logic [31:0]  u4_od;

  always #5 clk = ~clk;

  // LANES=16, 1 stage, inverse enabled
  sub_bytes_pipe #(.LANES(16), .PIPE_STAGES(1), .INV_EN(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u1_ir),
    .in_data(in_data), .in_inv(in_inv), .out_valid(u1_ov), .out_ready(out_ready),
    .out_data(u1_od), .out_inv(u1_oi), .busy(u1_busy));
  // LANES=16, 2 stages, inverse enabled
  sub_bytes_pipe #(.LANES(16), .PIPE_STAGES(2), .INV_EN(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u2_ir),
    .in_data(in_data), .in_inv(in_inv), .out_valid(u2_ov), .out_ready(out_ready),
    .out_data(u2_od), .out_inv(u2_oi), .busy(u2_busy));
  // LANES=16, 2 stages, forward only
  sub_bytes_pipe #(.LANES(16), .PIPE_STAGES(2), .INV_EN(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u0_ir),
    .in_data(in_data), .in_inv(in_inv), .out_valid(u0_ov), .out_ready(out_ready),
    .out_data(u0_od), .out_inv(u0_oi), .busy(u0_busy));
  // LANES=4 (SubWord), 2 stages, inverse enabled
  sub_bytes_pipe #(.LANES(4), .PIPE_STAGES(2), .INV_EN(1'b1)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u4_ir),
    .in_data(in_data[31:0]), .in_inv(in_inv), .out_valid(u4_ov), .out_ready(out_ready),
    .out_data(u4_od), .out_inv(u4_oi), .busy(u4_busy));

  // Instance under test for the generic streaming tasks
  int           sel = 0;
  logic         o_valid, o_inv, i_ready;
  logic [127:0] o_data;

  always_comb begin
    o_valid = u1_ov; o_inv = u1_oi; o_data = u1_od; i_ready = u1_ir;
    case (sel)
      1:       begin o_valid = u2_ov; o_inv = u2_oi; o_data = u2_od; i_ready = u2_ir; end
      2:       begin o_valid = u0_ov; o_inv = u0_oi; o_data = u0_od; i_ready = u0_ir; end
      3:       begin o_valid = u4_ov; o_inv = u4_oi; o_data = {96'h0, u4_od}; i_ready = u4_ir; end
      default: ;
    endcase
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [129:0] got, input logic [129:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference S-box built from GF(2^8) inversion plus the affine map
  logic [7:0] m_fwd [256];
  logic [7:0] m_inv [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_model();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] iv = 8'h00;
      logic [7:0] bx = 8'(x);
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(bx, 8'(y)) == 8'h01) iv = 8'(y);
      m_fwd[x] = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) m_inv[m_fwd[x]] = 8'(x);
  endtask

  logic [128:0] in_q[$];
  logic [128:0] exp_q[$];

  task automatic push_word(input logic [127:0] d, input logic inv, input int lanes, input bit inv_en);
    logic [127:0] e = '0;
    logic         ie = inv & inv_en;
    for (int i = 0; i < lanes; i++)
      e[8*i +: 8] = ie ? m_inv[d[8*i +: 8]] : m_fwd[d[8*i +: 8]];
    in_q.push_back({inv, d});
    exp_q.push_back({ie, e});
  endtask

  task automatic reset_all();
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_inv = 1'b0; in_data = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Streams in_q through the selected instance with random valid/ready,
  // checking order, content and stability while stalled.
  task automatic run(input string tag, input int vld_pct, input int rdy_pct, input int max_cyc);
    int           cyc = 0;
    logic         stalled = 1'b0;
    logic [128:0] held = '0;
    while ((in_q.size() > 0 || exp_q.size() > 0) && cyc < max_cyc) begin
      @(posedge clk); #1;
      if (in_q.size() > 0) begin
        in_valid = ($urandom_range(99) < vld_pct);
        {in_inv, in_data} = in_q[0];
      end else begin
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        in_inv   = 1'($urandom_range(1));
      end
      out_ready = ($urandom_range(99) < rdy_pct);
      @(negedge clk);
      if (stalled) check({tag, "_hold"}, {o_valid, o_inv, o_data}, {1'b1, held});
      if (in_valid && i_ready) void'(in_q.pop_front());
      if (o_valid && out_ready) begin
        if (exp_q.size() == 0) check({tag, "_spurious"}, 1'b1, 1'b0);
        else check(tag, {o_inv, o_data}, exp_q.pop_front());
      end
      stalled = o_valid && !out_ready;
      held    = {o_inv, o_data};
      cyc++;
    end
    check({tag, "_left"}, in_q.size() + exp_q.size(), 0);
    in_q.delete();
    exp_q.delete();
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check({tag, "_extra"}, o_valid, 1'b0);
    end
  endtask

  logic [31:0] rt_in  [64];
  logic [31:0] rt_mid [64];

  // Back-to-back stream of 64 SubWords through u4
  task automatic stream4(input bit phase);
    int          got = 0;
    int          first = -1;
    int          last = -1;
    logic [31:0] e;
    for (int c = 0; c < 72; c++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      if (c < 64) begin
        in_valid = 1'b1;
        in_inv   = phase;
        in_data  = {96'h0, phase ? rt_mid[c] : rt_in[c]};
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (c < 64) check("rt_in_ready", i_ready, 1'b1);
      if (o_valid) begin
        if (got < 64) begin
          if (!phase) begin
            for (int b = 0; b < 4; b++) e[8*b +: 8] = m_fwd[rt_in[got][8*b +: 8]];
            check("rt_fwd", {o_inv, o_data}, {1'b0, 96'h0, e});
            rt_mid[got] = o_data[31:0];
          end else begin
            check("rt_inv", {o_inv, o_data}, {1'b1, 96'h0, rt_in[got]});
          end
        end
        got++;
        if (first < 0) first = c;
        last = c;
      end
    end
    check("rt_count", got, 64);
    check("rt_b2b", last - first, 63);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]   bp_in  [5];
    logic [7:0]   bp_out [5];
    int           sent;
    bp_in  = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    bp_out = '{8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2};

    build_model();

    // Reset state
    reset_all();
    check("rst_u1_state", {u1_ov, u1_oi, u1_busy, u1_ir}, 4'b0001);
    check("rst_u1_data", u1_od, 128'h0);
    check("rst_u2_state", {u2_ov, u2_oi, u2_busy, u2_ir}, 4'b0001);
    check("rst_u2_data", u2_od, 128'h0);
    check("rst_busy_u0_u4", {u0_busy, u4_busy, u0_ir, u4_ir}, 4'b0011);

    // Forward, one stage: visible right after the accepting edge
    reset_all();
    @(posedge clk); #1;
    in_valid = 1'b1; in_inv = 1'b0; out_ready = 1'b1;
    in_data = 128'h00000000_00000000_00000000_01ff5300;
    @(negedge clk);
    check("fwd1_in_ready", u1_ir, 1'b1);
    check("fwd1_early", u1_ov, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("fwd1_valid", u1_ov, 1'b1);
    check("fwd1_data", {u1_oi, u1_od}, {1'b0, 128'h63636363_63636363_63636363_7c16ed63});
    @(posedge clk); #1;
    check("fwd1_drained", u1_ov, 1'b0);

    // Inverse, two stages; forward-only instance sees the same stimulus
    reset_all();
    @(posedge clk); #1;
    in_valid = 1'b1; in_inv = 1'b1; out_ready = 1'b1;
    in_data = 128'h63636363_63636363_63636363_7c16ed63;
    @(negedge clk);
    check("inv2_in_ready", u2_ir, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("inv2_early", {u2_ov, u0_ov}, 2'b00);
    @(posedge clk); #1;
    check("inv2_valid", {u2_ov, u0_ov}, 2'b11);
    check("inv2_data", {u2_oi, u2_od}, {1'b1, 128'h00000000_00000000_00000000_01ff5300});
    check("noinv_data", {u0_oi, u0_od}, {1'b0, 128'hfbfbfbfb_fbfbfbfb_fbfbfbfb_104755fb});

    // Exhaustive round trip on SubWord lanes
    for (int j = 0; j < 64; j++)
      for (int b = 0; b < 4; b++) rt_in[j][8*b +: 8] = 8'(4*j + b);
    reset_all();
    sel = 3;
    stream4(1'b0);
    stream4(1'b1);

    // Backpressure, two stages
    reset_all();
    sel = 1;
    sent = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; in_inv = 1'b0;
      in_data = {16{bp_in[sent]}};
      @(negedge clk);
      if (c >= 2) begin
        check("bp_in_ready", i_ready, 1'b0);
        check("bp_hold", {o_valid, o_inv, o_data}, {2'b10, {16{bp_out[0]}}});
      end
      if (i_ready) sent++;
    end
    check("bp_held_words", sent, 2);
    for (int k = 0; k < 5; k++) begin
      if (k < sent) exp_q.push_back({1'b0, {16{bp_out[k]}}});
      else begin
        in_q.push_back({1'b0, {16{bp_in[k]}}});
        exp_q.push_back({1'b0, {16{bp_out[k]}}});
      end
    end
    run("bp_release", 100, 100, 50);

    // Reset with two words in flight
    reset_all();
    sel = 1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; in_inv = 1'b0;
      in_data = {16{8'(8'h10 + c)}};
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rst_mid_busy_before", u2_busy, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_mid_state", {u2_ov, u2_busy, u2_ir, u2_oi}, 4'b0010);
    check("rst_mid_data", u2_od, 128'h0);
    push_word({16{8'h53}}, 1'b0, 16, 1'b1);
    run("rst_mid_next", 100, 100, 20);

    // Random valid/ready against the scoreboard
    reset_all();
    sel = 1;
    for (int k = 0; k < 10000; k++)
      push_word({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(1)), 16, 1'b1);
    run("rnd_u2", 70, 60, 60000);

    reset_all();
    sel = 0;
    for (int k = 0; k < 800; k++)
      push_word({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(1)), 16, 1'b1);
    run("rnd_u1", 70, 60, 5000);

    reset_all();
    sel = 2;
    for (int k = 0; k < 800; k++)
      push_word({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(1)), 16, 1'b0);
    run("rnd_u0", 70, 60, 5000);

    reset_all();
    sel = 3;
    for (int k = 0; k < 800; k++)
      push_word({96'h0, $urandom}, 1'($urandom_range(1)), 4, 1'b1);
    run("rnd_u4", 70, 60, 5000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
